// File: rtl/maltsev_pkg.sv
// Shared types and constants for the tree driver block.
package maltsev_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HOLD    = 2'd2,
        RECOVER = 2'd3
    } state_t;

endpackage

// File: rtl/tree_watchdog.sv
// Wait counter for the RUN state: cleared on job accept, counts RUN cycles,
// saturates at TIMEOUT-1 and flags expiry there.
module tree_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/tree_driver.sv
// Single-outstanding-job driver for an evaluation tree: launches operands,
// waits for RD or a timeout, holds the result until downstream takes it.
module tree_driver
    import maltsev_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             JOB_VAL,
    output logic             JOB_RDY,
    input  logic [WIDTH-1:0] J0,
    input  logic [WIDTH-1:0] J1,
    input  logic [WIDTH-1:0] J2,
    input  logic [WIDTH-1:0] J3,
    input  logic [WIDTH-1:0] J4,
    output logic             ST,
    output logic [WIDTH-1:0] IN0,
    output logic [WIDTH-1:0] IN1,
    output logic [WIDTH-1:0] IN2,
    output logic [WIDTH-1:0] IN3,
    output logic [WIDTH-1:0] IN4,
    input  logic             RD,
    input  logic [WIDTH-1:0] RES,
    output logic             OUT_VAL,
    input  logic             OUT_RDY,
    output logic [WIDTH-1:0] OUT_RES,
    output logic             OUT_TO,
    output logic             BUSY
);

    state_t state;
    state_t state_next;
    logic   accept;
    logic   expired;

    assign accept = JOB_VAL && JOB_RDY;

    tree_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (CLK),
        .clear  (!RST || accept),
        .enable (state == RUN),
        .expired(expired)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept)          state_next = RUN;
            RUN:     if (RD || expired)   state_next = HOLD;
            HOLD:    if (OUT_RDY)         state_next = RECOVER;
            RECOVER: if (!RD)             state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    // JOB_RDY waits for a stale RD to drop so ST never meets a leftover RD.
    always_comb begin
        JOB_RDY = 1'b0;
        ST      = 1'b0;
        OUT_VAL = 1'b0;
        BUSY    = 1'b1;
        unique case (state)
            IDLE: begin
                JOB_RDY = !RD;
                BUSY    = 1'b0;
            end
            RUN:     ST      = 1'b1;
            HOLD:    OUT_VAL = 1'b1;
            RECOVER: ;
            default: ;
        endcase
    end

    // RD takes priority over expiry when both land on the same edge.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            IN0     <= '0;
            IN1     <= '0;
            IN2     <= '0;
            IN3     <= '0;
            IN4     <= '0;
            OUT_RES <= '0;
            OUT_TO  <= 1'b0;
        end else begin
            if (accept) begin
                IN0 <= J0;
                IN1 <= J1;
                IN2 <= J2;
                IN3 <= J3;
                IN4 <= J4;
            end
            if (state == RUN) begin
                if (RD) begin
                    OUT_RES <= RES;
                    OUT_TO  <= 1'b0;
                end else if (expired) begin
                    OUT_RES <= '0;
                    OUT_TO  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tree_driver.sv
// Directed bench for tree_driver with a result scoreboard and handshake monitor.
module tb_tree_driver;

    localparam int W  = 16;
    localparam int TO = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         JOB_VAL = 1'b0;
    logic         JOB_RDY;
    logic [W-1:0] J0 = '0, J1 = '0, J2 = '0, J3 = '0, J4 = '0;
    logic         ST;
    logic [W-1:0] IN0, IN1, IN2, IN3, IN4;
    logic         RD = 1'b0;
    logic [W-1:0] RES = 16'hDEAD;
    logic         OUT_VAL;
    logic         OUT_RDY = 1'b0;
    logic [W-1:0] OUT_RES;
    logic         OUT_TO;
    logic         BUSY;

    tree_driver #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .JOB_VAL(JOB_VAL), .JOB_RDY(JOB_RDY),
        .J0(J0), .J1(J1), .J2(J2), .J3(J3), .J4(J4),
        .ST(ST), .IN0(IN0), .IN1(IN1), .IN2(IN2), .IN3(IN3), .IN4(IN4),
        .RD(RD), .RES(RES), .OUT_VAL(OUT_VAL), .OUT_RDY(OUT_RDY),
        .OUT_RES(OUT_RES), .OUT_TO(OUT_TO), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [W-1:0] res;
        logic         to;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Result monitor: compares at every output handshake.
    always @(negedge CLK) begin
        if (RST && OUT_VAL && OUT_RDY) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("out_res", 32'(OUT_RES), 32'(mon_e.res));
                chk("out_to", 32'(OUT_TO), 32'(mon_e.to));
            end
        end
    end

    task automatic wait_job_rdy(input string tag);
        int k;
        k = 0;
        @(negedge CLK);
        while (!JOB_RDY && k < 50) begin
            @(negedge CLK);
            k++;
        end
        chk({tag, "_job_rdy"}, 32'(JOB_RDY), 32'd1);
    endtask

    task automatic run_job(input logic [W-1:0] a, b, c, d, e, input int rd_after,
                           input logic [W-1:0] res, input logic exp_to, input int exp_st,
                           input int hold, input int stale, input string tag);
        int cyc, rc, exp_rc;
        logic ok;
        logic [W-1:0] held_res;
        exp_t x;
        wait_job_rdy(tag);
        J0 = a; J1 = b; J2 = c; J3 = d; J4 = e;
        JOB_VAL = 1'b1;
        x.res = exp_to ? '0 : res;
        x.to  = exp_to;
        sb.push_back(x);
        RES = 16'hDEAD;
        @(posedge CLK);
        #1;
        JOB_VAL = 1'b0;
        J0 = 16'hBAD0; J1 = 16'hBAD1; J2 = 16'hBAD2; J3 = 16'hBAD3; J4 = 16'hBAD4;
        cyc = 0;
        ok  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (!ST) break;
            cyc++;
            if ({IN0, IN1, IN2, IN3, IN4} !== {a, b, c, d, e} || JOB_RDY) ok = 1'b0;
            if (cyc == rd_after) begin
                RD  = 1'b1;
                RES = res;
            end
        end
        chk({tag, "_st_cycles"}, 32'(cyc), 32'(exp_st));
        chk({tag, "_in_held"}, 32'(ok), 32'd1);
        chk({tag, "_out_val_latency"}, 32'(OUT_VAL), 32'd1);
        if (stale == 0) RD = 1'b0;
        held_res = OUT_RES;
        ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (!OUT_VAL || ST || JOB_RDY || OUT_RES !== held_res) ok = 1'b0;
            @(negedge CLK);
        end
        if (hold > 0) chk({tag, "_hold_stable"}, 32'(ok), 32'd1);
        @(posedge CLK);
        #1 OUT_RDY = 1'b1;
        @(posedge CLK);
        #1 OUT_RDY = 1'b0;
        rc = 0;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (!BUSY) break;
            rc++;
            if (JOB_RDY || ST || OUT_VAL) ok = 1'b0;
            if (rc >= stale) RD = 1'b0;
        end
        exp_rc = (stale > 1) ? stale : 1;
        chk({tag, "_recover_cycles"}, 32'(rc), 32'(exp_rc));
        chk({tag, "_recover_quiet"}, 32'(ok), 32'd1);
        chk({tag, "_job_rdy_back"}, 32'(JOB_RDY), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_st", 32'(ST), 32'd0);
        chk("rst_out_val", 32'(OUT_VAL), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_out", {15'd0, OUT_TO, OUT_RES}, 32'd0);
        chk("rst_in", 32'(IN0 | IN1 | IN2 | IN3 | IN4), 32'd0);
        RST = 1'b1;
        RD  = 1'b1;
        @(negedge CLK);
        chk("idle_rd_high_blocks", 32'(JOB_RDY), 32'd0);
        RD = 1'b0;
        #1;
        chk("idle_rd_low_ready", 32'(JOB_RDY), 32'd1);

        run_job(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 4, 16'h000F, 1'b0, 4, 0, 0, "normal");
        run_job(16'h11, 16'h22, 16'h33, 16'h44, 16'h55, 0, 16'h0000, 1'b1, TO, 0, 0, "timeout");
        run_job(16'hA, 16'hB, 16'hC, 16'hD, 16'hE, 2, 16'hABCD, 1'b0, 2, 10, 0, "backpressure");
        run_job(16'h7, 16'h6, 16'h5, 16'h4, 16'h3, 3, 16'h0055, 1'b0, 3, 0, 3, "stale");
        run_job(16'h9, 16'h8, 16'h7, 16'h6, 16'h5, TO, 16'h1234, 1'b0, TO, 0, 0, "tie");

        // Reset asserted during the second RUN cycle discards the job.
        wait_job_rdy("rstrun");
        J0 = 16'h0101; J1 = 16'h0202; J2 = 16'h0303; J3 = 16'h0404; J4 = 16'h0505;
        JOB_VAL = 1'b1;
        @(posedge CLK);
        #1 JOB_VAL = 1'b0;
        @(negedge CLK);
        chk("rstrun_st_c1", 32'(ST), 32'd1);
        @(negedge CLK);
        chk("rstrun_st_c2", 32'(ST), 32'd1);
        RST = 1'b0;
        @(negedge CLK);
        chk("rstrun_st", 32'(ST), 32'd0);
        chk("rstrun_out_val", 32'(OUT_VAL), 32'd0);
        chk("rstrun_busy", 32'(BUSY), 32'd0);
        chk("rstrun_in", 32'(IN0 | IN1 | IN2 | IN3 | IN4), 32'd0);
        RST = 1'b1;

        run_job(16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 1, 16'h0F0F, 1'b0, 1, 0, 0, "after_rst");

        repeat (3) @(negedge CLK);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
